// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared types and constants for the machine-mode CSR unit (csr_unit).
//   csr_addrs_e  : implemented CSR addresses (mcycle only decoded when the
//                  CSR_MCYCLE_EN build macro is defined)
//   csr_mcause_e : exception / interrupt cause encodings
//   mstatus_t    : mstatus field layout
//   csr_op_e     : CSR access operation
//   csr_state_e  : request/response FSM states
//   MisaValue, MieMask, MstatusWMask : fixed CSR values and writable masks
//   mtvec_warl() : legalises a write to mtvec
// -----------------------------------------------------------------------------
package csr_pkg;

  typedef enum logic [11:0] {
    CSRmstatus  = 12'h300,
    CSRmisa     = 12'h301,
    CSRmie      = 12'h304,
    CSRmtvec    = 12'h305,
    CSRmstatush = 12'h310,
    CSRmscratch = 12'h340,
    CSRmepc     = 12'h341,
    CSRmcause   = 12'h342,
    CSRmtval    = 12'h343,
    CSRmip      = 12'h344,
    CSRmcycle   = 12'hB00,
    CSRmhartid  = 12'hF14
  } csr_addrs_e;

  typedef enum logic [63:0] {
    InstrAddrMisaligned = 64'd0,
    InstrAccessFault    = 64'd1,
    IllegalInstr        = 64'd2,
    Breakpoint          = 64'd3,
    LoadAddrMisaligned  = 64'd4,
    LoadAccessFault     = 64'd5,
    StoreAddrMisaligned = 64'd6,
    StoreAccessFault    = 64'd7,
    EcallU              = 64'd8,
    EcallM              = 64'd11,
    MSoftInt            = 64'h8000_0000_0000_0003,
    MTimerInt           = 64'h8000_0000_0000_0007,
    MExtInt             = 64'h8000_0000_0000_000B
  } csr_mcause_e;

  typedef struct packed {
    logic [50:0] rsvd_hi;   // [63:13]
    logic [1:0]  mpp;       // [12:11]
    logic [2:0]  rsvd_mid;  // [10:8]
    logic        mpie;      // [7]
    logic [2:0]  rsvd_lo;   // [6:4]
    logic        mie;       // [3]
    logic [2:0]  rsvd_0;    // [2:0]
  } mstatus_t;

  typedef enum logic [1:0] {
    CsrIllegal = 2'b00,
    CsrRW      = 2'b01,
    CsrRS      = 2'b10,
    CsrRC      = 2'b11
  } csr_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StResp = 1'b1
  } csr_state_e;

  localparam logic [63:0] MisaValue    = 64'h8000_0000_0000_0100;
  localparam logic [63:0] MieMask      = 64'h0000_0000_0000_0888;
  localparam logic [63:0] MstatusWMask = 64'h0000_0000_0000_0088;

  // Modes 2 and 3 are reserved: such a write keeps the previous mode while
  // still updating the base.
  function automatic logic [63:0] mtvec_warl(input logic [63:0] cur,
                                             input logic [63:0] nv);
    logic [1:0] mode;
    if (nv[1]) begin
      mode = cur[1:0];
    end else begin
      mode = nv[1:0];
    end
    return {nv[63:2], mode};
  endfunction

endpackage

// File: rtl/csr_counter.sv
// -----------------------------------------------------------------------------
// csr_counter
// 64-bit free-running cycle counter with a write port. A write takes priority
// over the increment in the same cycle; the count wraps at 2^64.
// Ports:
//   clk    in  : clock
//   rst_n  in  : asynchronous active-low reset (count -> 0)
//   we     in  : load wdata this cycle
//   wdata  in  : load value
//   count  out : current count (registered)
// Only instantiated by csr_unit when CSR_MCYCLE_EN is defined.
// -----------------------------------------------------------------------------
module csr_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [63:0] wdata,
  output logic [63:0] count
);

  logic [63:0] count_r;

  // Counter register: load has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 64'd0;
    end else if (we) begin
      count_r <= wdata;
    end else begin
      count_r <= count_r + 64'd1;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/csr_unit.sv
// -----------------------------------------------------------------------------
// csr_unit
// Machine-mode CSR responder and trap sequencer for the RV64 core.
// Build option: CSR_MCYCLE_EN -- when defined, mcycle (12'hB00) is implemented
// by a csr_counter instance; otherwise 12'hB00 decodes as an unknown address.
// Parameters: HartId (mhartid value), ResetMtvec (mtvec reset value).
// Ports:
//   clk_i, rst_ni                      : clock, async active-low reset
//   req_valid_i/req_ready_o            : CSR request handshake
//   req_op_i, req_addr_i, req_wdata_i  : operation, address, operand
//   req_wen_i                          : 0 suppresses RS/RC write
//   rsp_valid_o/rsp_ready_i            : response handshake
//   rsp_rdata_o, rsp_illegal_o         : old value, illegal-access flag
//   trap_valid_i, trap_cause_i,
//   trap_pc_i, trap_tval_i             : trap entry
//   mret_i                             : return from trap
//   irq_msip_i, irq_mtip_i, irq_meip_i : interrupt lines
//   irq_take_o                         : enabled interrupt pending
//   redirect_valid_o, redirect_pc_o    : one-cycle fetch redirect
// -----------------------------------------------------------------------------
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [63:0] HartId     = 64'd0,
  parameter logic [63:0] ResetMtvec = 64'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [11:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic        req_wen_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_illegal_o,
  input  logic        trap_valid_i,
  input  logic [63:0] trap_cause_i,
  input  logic [63:0] trap_pc_i,
  input  logic [63:0] trap_tval_i,
  input  logic        mret_i,
  input  logic        irq_msip_i,
  input  logic        irq_mtip_i,
  input  logic        irq_meip_i,
  output logic        irq_take_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o
);

  csr_state_e  state_r, state_d;
  csr_addrs_e  addr_s;
  csr_op_e     op_s;
  mstatus_t    mstatus_s;

  logic        st_mie_r, st_mpie_r;
  logic [63:0] mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r;
  logic [63:0] mip_s, old_s, new_s, trap_target_s, redirect_pc_s;
  logic        known_s, write_s, illegal_s, accept_s, commit_s;

  logic        rsp_valid_r, rsp_illegal_r, redirect_valid_r;
  logic [63:0] rsp_rdata_r, redirect_pc_r;

`ifdef CSR_MCYCLE_EN
  logic [63:0] mcycle_s;
`endif

  assign addr_s = csr_addrs_e'(req_addr_i);
  assign op_s   = csr_op_e'(req_op_i);

  assign mip_s = {52'd0, irq_meip_i, 3'd0, irq_mtip_i, 3'd0, irq_msip_i, 3'd0};

  // Architectural view of mstatus: only mie/mpie are stored, mpp is fixed M.
  always_comb begin
    mstatus_s      = '0;
    mstatus_s.mpp  = 2'b11;
    mstatus_s.mie  = st_mie_r;
    mstatus_s.mpie = st_mpie_r;
  end

  // Read mux: current value of the addressed CSR and whether it exists.
  always_comb begin
    old_s   = 64'd0;
    known_s = 1'b1;
    case (addr_s)
      CSRmstatus:  old_s = mstatus_s;
      CSRmisa:     old_s = MisaValue;
      CSRmie:      old_s = mie_r;
      CSRmtvec:    old_s = mtvec_r;
      CSRmstatush: old_s = 64'd0;
      CSRmscratch: old_s = mscratch_r;
      CSRmepc:     old_s = mepc_r;
      CSRmcause:   old_s = mcause_r;
      CSRmtval:    old_s = mtval_r;
      CSRmip:      old_s = mip_s;
      CSRmhartid:  old_s = HartId;
`ifdef CSR_MCYCLE_EN
      CSRmcycle:   old_s = mcycle_s;
`endif
      default:     known_s = 1'b0;
    endcase
  end

  // Read-modify-write value for the requested operation.
  always_comb begin
    new_s = old_s;
    case (op_s)
      CsrRW:   new_s = req_wdata_i;
      CsrRS:   new_s = old_s | req_wdata_i;
      CsrRC:   new_s = old_s & ~req_wdata_i;
      default: new_s = old_s;
    endcase
  end

  // RW always writes; RS/RC write only with a non-x0 source (req_wen_i).
  assign write_s   = (op_s == CsrRW) | req_wen_i;
  assign illegal_s = ~known_s | (op_s == CsrIllegal) |
                     (write_s & (req_addr_i[11:10] == 2'b11));

  // Trap and mret cycles block acceptance, so commits never race trap updates.
  assign req_ready_o = (state_r == StIdle) & ~trap_valid_i & ~mret_i;
  assign accept_s    = req_valid_i & req_ready_o;
  assign commit_s    = accept_s & ~illegal_s & write_s;

  // Trap vector: vectored mode offsets interrupts by 4*cause.
  always_comb begin
    trap_target_s = {mtvec_r[63:2], 2'b00};
    if ((mtvec_r[1:0] == 2'b01) && trap_cause_i[63]) begin
      trap_target_s = {mtvec_r[63:2], 2'b00} + {56'd0, trap_cause_i[5:0], 2'b00};
    end else begin
      trap_target_s = {mtvec_r[63:2], 2'b00};
    end
  end

  // Redirect target selection: trap wins over a same-cycle mret.
  always_comb begin
    redirect_pc_s = redirect_pc_r;
    if (trap_valid_i) begin
      redirect_pc_s = trap_target_s;
    end else if (mret_i) begin
      redirect_pc_s = mepc_r;
    end else begin
      redirect_pc_s = redirect_pc_r;
    end
  end

  // FSM next state: a trap abandons a pending response.
  always_comb begin
    state_d = state_r;
    case (state_r)
      StIdle: begin
        if (accept_s) begin
          state_d = StResp;
        end else begin
          state_d = StIdle;
        end
      end
      StResp: begin
        if (trap_valid_i || rsp_ready_i) begin
          state_d = StIdle;
        end else begin
          state_d = StResp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and registered response / redirect outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r          <= StIdle;
      rsp_valid_r      <= 1'b0;
      rsp_rdata_r      <= 64'd0;
      rsp_illegal_r    <= 1'b0;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 64'd0;
    end else begin
      state_r          <= state_d;
      rsp_valid_r      <= (state_d == StResp);
      redirect_valid_r <= trap_valid_i | mret_i;
      redirect_pc_r    <= redirect_pc_s;
      if (accept_s) begin
        rsp_rdata_r   <= illegal_s ? 64'd0 : old_s;
        rsp_illegal_r <= illegal_s;
      end
    end
  end

  // CSR storage: trap, then mret, then software writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_mie_r   <= 1'b0;
      st_mpie_r  <= 1'b0;
      mie_r      <= 64'd0;
      mtvec_r    <= ResetMtvec;
      mscratch_r <= 64'd0;
      mepc_r     <= 64'd0;
      mcause_r   <= 64'd0;
      mtval_r    <= 64'd0;
    end else if (trap_valid_i) begin
      mepc_r    <= {trap_pc_i[63:2], 2'b00};
      mcause_r  <= trap_cause_i;
      mtval_r   <= trap_tval_i;
      st_mpie_r <= st_mie_r;
      st_mie_r  <= 1'b0;
    end else if (mret_i) begin
      st_mie_r  <= st_mpie_r;
      st_mpie_r <= 1'b1;
    end else if (commit_s) begin
      case (addr_s)
        CSRmstatus: begin
          st_mie_r  <= new_s[3] & MstatusWMask[3];
          st_mpie_r <= new_s[7] & MstatusWMask[7];
        end
        CSRmie:      mie_r      <= new_s & MieMask;
        CSRmtvec:    mtvec_r    <= mtvec_warl(mtvec_r, new_s);
        CSRmscratch: mscratch_r <= new_s;
        CSRmepc:     mepc_r     <= {new_s[63:2], 2'b00};
        CSRmcause:   mcause_r   <= new_s;
        CSRmtval:    mtval_r    <= new_s;
        default:     ;
      endcase
    end
  end

`ifdef CSR_MCYCLE_EN
  csr_counter u_mcycle (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .we    (commit_s && (addr_s == CSRmcycle)),
    .wdata (new_s),
    .count (mcycle_s)
  );
`endif

  assign irq_take_o       = st_mie_r & |(mie_r & mip_s);
  assign rsp_valid_o      = rsp_valid_r;
  assign rsp_rdata_o      = rsp_rdata_r;
  assign rsp_illegal_o    = rsp_illegal_r;
  assign redirect_valid_o = redirect_valid_r;
  assign redirect_pc_o    = redirect_pc_r;

endmodule

// File: tb/tb_csr_unit.sv
// -----------------------------------------------------------------------------
// tb_csr_unit
// Self-checking bench for csr_unit: directed scenarios plus a randomized
// sequence of accesses, traps, mrets and interrupt-line changes, all checked
// against an architectural model of the machine-mode CSRs.
// Honours CSR_MCYCLE_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_csr_unit;

  localparam logic [63:0] HART      = 64'h5;
  localparam logic [63:0] RST_MTVEC = 64'h100;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [11:0] req_addr = 12'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_illegal;
  logic [63:0] rsp_rdata;
  logic        trap_valid = 1'b0, mret = 1'b0;
  logic [63:0] trap_cause = 64'd0, trap_pc = 64'd0, trap_tval = 64'd0;
  logic        msip = 1'b0, mtip = 1'b0, meip = 1'b0, irq_take;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  csr_unit #(.HartId(HART), .ResetMtvec(RST_MTVEC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wen_i(req_wen),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_illegal_o(rsp_illegal),
    .trap_valid_i(trap_valid), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc),
    .trap_tval_i(trap_tval), .mret_i(mret),
    .irq_msip_i(msip), .irq_mtip_i(mtip), .irq_meip_i(meip), .irq_take_o(irq_take),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // ---------------- architectural reference model ----------------
  logic        m_st_mie, m_st_mpie;
  logic [63:0] m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;

  function automatic void model_reset();
    m_st_mie = 1'b0; m_st_mpie = 1'b0; m_mie = 64'd0; m_mtvec = RST_MTVEC;
    m_mscratch = 64'd0; m_mepc = 64'd0; m_mcause = 64'd0; m_mtval = 64'd0;
  endfunction

  function automatic void model_read(input logic [11:0] addr, output logic known,
                                     output logic [63:0] val);
    known = 1'b1;
    val   = 64'd0;
    case (addr)
      12'h300: val = 64'h1800 + (m_st_mie ? 64'd8 : 64'd0) + (m_st_mpie ? 64'd128 : 64'd0);
      12'h301: val = 64'h8000_0000_0000_0100;
      12'h304: val = m_mie;
      12'h305: val = m_mtvec;
      12'h310: val = 64'd0;
      12'h340: val = m_mscratch;
      12'h341: val = m_mepc;
      12'h342: val = m_mcause;
      12'h343: val = m_mtval;
      12'h344: val = (msip ? 64'd8 : 64'd0) + (mtip ? 64'd128 : 64'd0) + (meip ? 64'd2048 : 64'd0);
      12'hF14: val = HART;
      default: known = 1'b0;
    endcase
  endfunction

  function automatic void model_access(input logic [1:0] op, input logic [11:0] addr,
                                       input logic [63:0] w, input logic wen,
                                       output logic [63:0] e_rd, output logic e_ill);
    logic known, wr;
    logic [63:0] old, nv;
    model_read(addr, known, old);
    wr    = (op == 2'd1) || wen;
    e_ill = !known || (op == 2'd0) || (wr && (addr[11:10] == 2'b11));
    e_rd  = e_ill ? 64'd0 : old;
    nv    = (op == 2'd1) ? w : ((op == 2'd2) ? (old | w) : (old & ~w));
    if (!e_ill && wr) begin
      case (addr)
        12'h300: begin m_st_mie = nv[3]; m_st_mpie = nv[7]; end
        12'h304: m_mie = nv & 64'h888;
        12'h305: m_mtvec = (nv[1:0] < 2'd2) ? nv : {nv[63:2], m_mtvec[1:0]};
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~64'd3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        default: ;
      endcase
    end
  endfunction

  function automatic logic [63:0] model_target(input logic [63:0] cause);
    logic [63:0] base;
    base = m_mtvec & ~64'd3;
    if ((m_mtvec % 64'd4 == 64'd1) && cause[63]) return base + 64'd4 * (cause % 64'd64);
    return base;
  endfunction

  function automatic void model_trap(input logic [63:0] cause, pc, tval);
    m_mepc = pc & ~64'd3; m_mcause = cause; m_mtval = tval;
    m_st_mpie = m_st_mie; m_st_mie = 1'b0;
  endfunction

  function automatic void model_mret();
    m_st_mie = m_st_mpie; m_st_mpie = 1'b1;
  endfunction

  function automatic logic model_irq();
    logic k;
    logic [63:0] mip;
    model_read(12'h344, k, mip);
    return m_st_mie && ((m_mie & mip) != 64'd0);
  endfunction

  // ---------------- stimulus drivers (capture only) ----------------
  logic        obs_rdy, obs_vld, obs_ill, obs_busy, obs_after;
  logic [63:0] obs_rd;
  int          obs_held;
  logic        ev_rdy, ev_rv, ev_after;
  logic [63:0] ev_pc;
  logic [63:0] exp_rd;
  logic        exp_ill;

  task automatic do_access(input logic [1:0] op, input logic [11:0] addr,
                           input logic [63:0] w, input logic wen, input int hold);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = w; req_wen = wen;
    rsp_ready = 1'b0;
    #1 obs_rdy = req_ready;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    obs_vld = rsp_valid; obs_rd = rsp_rdata; obs_ill = rsp_illegal; obs_busy = req_ready;
    obs_held = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid && (rsp_rdata === obs_rd) && (rsp_illegal === obs_ill)) obs_held++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    obs_after = rsp_valid;
  endtask

  task automatic do_event(input logic t, input logic m, input logic [63:0] cause, pc, tval);
    @(negedge clk);
    trap_valid = t; mret = m; trap_cause = cause; trap_pc = pc; trap_tval = tval;
    #1 ev_rdy = req_ready;
    @(posedge clk);
    #1 trap_valid = 1'b0; mret = 1'b0;
    @(negedge clk);
    ev_rv = redirect_valid; ev_pc = redirect_pc;
    @(negedge clk);
    ev_after = redirect_valid;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready); else pass_cnt++;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (rsp_rdata !== 64'd0) $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); else pass_cnt++;
    total_cnt++; if (redirect_valid !== 1'b0) $display("FAIL reset_redirect_valid: got %b expected 0", redirect_valid); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 64'd0) $display("FAIL reset_redirect_pc: got %h expected 0", redirect_pc); else pass_cnt++;
    total_cnt++; if (irq_take !== 1'b0) $display("FAIL reset_irq_take: got %b expected 0", irq_take); else pass_cnt++;
    rst_n = 1'b1;
    model_reset();
    do_access(2'd2, 12'h305, 64'd0, 1'b0, 0);
    total_cnt++; if (obs_rd !== RST_MTVEC) $display("FAIL reset_mtvec: got %h expected %h", obs_rd, RST_MTVEC); else pass_cnt++;
    do_access(2'd2, 12'h300, 64'd0, 1'b0, 0);
    total_cnt++; if (obs_rd !== 64'h1800) $display("FAIL reset_mstatus: got %h expected 1800", obs_rd); else pass_cnt++;
    // reset while a response is pending discards it
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_addr = 12'h340; req_wdata = 64'h77; req_wen = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL midreset_pending: got %b expected 1", rsp_valid); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL midreset_rsp_valid: got %b expected 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL midreset_req_ready: got %b expected 1", req_ready); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_mscratch();
    model_access(2'd1, 12'h340, 64'hDEAD_BEEF, 1'b0, exp_rd, exp_ill);
    do_access(2'd1, 12'h340, 64'hDEAD_BEEF, 1'b0, 0);
    total_cnt++; if (obs_rdy !== 1'b1) $display("FAIL mscratch_accept: got %b expected 1", obs_rdy); else pass_cnt++;
    total_cnt++; if (obs_rd !== 64'd0) $display("FAIL mscratch_first_rdata: got %h expected 0", obs_rd); else pass_cnt++;
    model_access(2'd2, 12'h340, 64'd0, 1'b0, exp_rd, exp_ill);
    do_access(2'd2, 12'h340, 64'd0, 1'b0, 3);
    total_cnt++; if (obs_rd !== 64'hDEAD_BEEF) $display("FAIL mscratch_readback: got %h expected deadbeef", obs_rd); else pass_cnt++;
    total_cnt++; if (obs_held !== 3) $display("FAIL rsp_hold: got %0d expected 3 stable cycles", obs_held); else pass_cnt++;
    total_cnt++; if (obs_busy !== 1'b0) $display("FAIL ready_in_resp: got %b expected 0", obs_busy); else pass_cnt++;
    total_cnt++; if (obs_after !== 1'b0) $display("FAIL rsp_release: got %b expected 0", obs_after); else pass_cnt++;
  endtask

  task automatic test_mtvec_warl();
    model_access(2'd1, 12'h305, 64'h1003, 1'b0, exp_rd, exp_ill);
    do_access(2'd1, 12'h305, 64'h1003, 1'b0, 0);
    do_access(2'd2, 12'h305, 64'd0, 1'b0, 0);
    total_cnt++; if (obs_rd !== 64'h1000) $display("FAIL mtvec_warl: got %h expected 1000", obs_rd); else pass_cnt++;
    model_access(2'd1, 12'h341, 64'h1237, 1'b0, exp_rd, exp_ill);
    do_access(2'd1, 12'h341, 64'h1237, 1'b0, 0);
    do_access(2'd2, 12'h341, 64'd0, 1'b0, 0);
    total_cnt++; if (obs_rd !== 64'h1234) $display("FAIL mepc_align: got %h expected 1234", obs_rd); else pass_cnt++;
  endtask

  task automatic test_illegal();
    do_access(2'd1, 12'hF14, 64'h1, 1'b0, 0);
    total_cnt++; if (obs_ill !== 1'b1 || obs_rd !== 64'd0) $display("FAIL ro_write: got ill=%b rd=%h expected ill=1 rd=0", obs_ill, obs_rd); else pass_cnt++;
    do_access(2'd2, 12'hF14, 64'h1, 1'b0, 0);
    total_cnt++; if (obs_ill !== 1'b0 || obs_rd !== HART) $display("FAIL hartid_read: got ill=%b rd=%h expected ill=0 rd=%h", obs_ill, obs_rd, HART); else pass_cnt++;
    do_access(2'd0, 12'h340, 64'h1, 1'b0, 0);
    total_cnt++; if (obs_ill !== 1'b1) $display("FAIL op00: got ill=%b expected 1", obs_ill); else pass_cnt++;
    do_access(2'd2, 12'h7C0, 64'h1, 1'b1, 0);
    total_cnt++; if (obs_ill !== 1'b1) $display("FAIL unknown_addr: got ill=%b expected 1", obs_ill); else pass_cnt++;
    do_access(2'd2, 12'h310, 64'hFF, 1'b1, 0);
    total_cnt++; if (obs_ill !== 1'b0 || obs_rd !== 64'd0) $display("FAIL mstatush: got ill=%b rd=%h expected ill=0 rd=0", obs_ill, obs_rd); else pass_cnt++;
    do_access(2'd2, 12'h340, 64'd0, 1'b0, 0);
    total_cnt++; if (obs_rd !== m_mscratch) $display("FAIL illegal_no_effect: got %h expected %h", obs_rd, m_mscratch); else pass_cnt++;
  endtask

  task automatic test_exception_trap();
    model_access(2'd2, 12'h300, 64'h8, 1'b1, exp_rd, exp_ill);
    do_access(2'd2, 12'h300, 64'h8, 1'b1, 0);
    model_access(2'd1, 12'h305, 64'h8000_0001, 1'b0, exp_rd, exp_ill);
    do_access(2'd1, 12'h305, 64'h8000_0001, 1'b0, 0);
    do_event(1'b1, 1'b0, 64'd11, 64'h1002, 64'hBAD);
    model_trap(64'd11, 64'h1002, 64'hBAD);
    total_cnt++; if (ev_rdy !== 1'b0) $display("FAIL trap_blocks_req: got %b expected 0", ev_rdy); else pass_cnt++;
    total_cnt++; if (ev_rv !== 1'b1 || ev_pc !== 64'h8000_0000) $display("FAIL trap_redirect: got v=%b pc=%h expected v=1 pc=80000000", ev_rv, ev_pc); else pass_cnt++;
    total_cnt++; if (ev_after !== 1'b0) $display("FAIL redirect_pulse: got %b expected 0", ev_after); else pass_cnt++;
    do_access(2'd2, 12'h341, 64'd0, 1'b0, 0);
    total_cnt++; if (obs_rd !== 64'h1000) $display("FAIL trap_mepc: got %h expected 1000", obs_rd); else pass_cnt++;
    do_access(2'd2, 12'h300, 64'd0, 1'b0, 0);
    total_cnt++; if (obs_rd !== 64'h1880) $display("FAIL trap_mstatus: got %h expected 1880", obs_rd); else pass_cnt++;
    do_access(2'd2, 12'h342, 64'd0, 1'b0, 0);
    total_cnt++; if (obs_rd !== 64'd11) $display("FAIL trap_mcause: got %h expected b", obs_rd); else pass_cnt++;
    do_event(1'b0, 1'b1, 64'd0, 64'd0, 64'd0);
    model_mret();
    total_cnt++; if (ev_rv !== 1'b1 || ev_pc !== 64'h1000) $display("FAIL mret_redirect: got v=%b pc=%h expected v=1 pc=1000", ev_rv, ev_pc); else pass_cnt++;
    do_access(2'd2, 12'h300, 64'd0, 1'b0, 0);
    total_cnt++; if (obs_rd !== 64'h1888) $display("FAIL mret_mstatus: got %h expected 1888", obs_rd); else pass_cnt++;
  endtask

  task automatic test_interrupt();
    model_access(2'd1, 12'h304, 64'h80, 1'b0, exp_rd, exp_ill);
    do_access(2'd1, 12'h304, 64'h80, 1'b0, 0);
    @(negedge clk); mtip = 1'b0; #1;
    total_cnt++; if (irq_take !== 1'b0) $display("FAIL irq_idle: got %b expected 0", irq_take); else pass_cnt++;
    @(negedge clk); mtip = 1'b1; #1;
    total_cnt++; if (irq_take !== 1'b1) $display("FAIL irq_take: got %b expected 1", irq_take); else pass_cnt++;
    do_access(2'd2, 12'h344, 64'd0, 1'b0, 0);
    total_cnt++; if (obs_rd !== 64'h80) $display("FAIL mip_mirror: got %h expected 80", obs_rd); else pass_cnt++;
    model_access(2'd1, 12'h305, 64'h8001, 1'b0, exp_rd, exp_ill);
    do_access(2'd1, 12'h305, 64'h8001, 1'b0, 0);
    do_event(1'b1, 1'b0, 64'h8000_0000_0000_0007, 64'h3000, 64'd0);
    model_trap(64'h8000_0000_0000_0007, 64'h3000, 64'd0);
    total_cnt++; if (ev_rv !== 1'b1 || ev_pc !== 64'h801C) $display("FAIL vectored_redirect: got v=%b pc=%h expected v=1 pc=801c", ev_rv, ev_pc); else pass_cnt++;
    total_cnt++; if (irq_take !== 1'b0) $display("FAIL irq_masked_after_trap: got %b expected 0", irq_take); else pass_cnt++;
    mtip = 1'b0;
  endtask

  task automatic test_trap_mret_resp();
    logic [63:0] tgt;
    model_access(2'd1, 12'h340, 64'h55, 1'b0, exp_rd, exp_ill);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_addr = 12'h340; req_wdata = 64'h55; req_wen = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    tgt = model_target(64'd11);
    trap_valid = 1'b1; mret = 1'b1; trap_cause = 64'd11; trap_pc = 64'h2000; trap_tval = 64'd0;
    @(posedge clk);
    #1 trap_valid = 1'b0; mret = 1'b0;
    model_trap(64'd11, 64'h2000, 64'd0);
    @(negedge clk);
    total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL trap_drops_rsp: got %b expected 0", rsp_valid); else pass_cnt++;
    total_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== tgt) $display("FAIL trap_over_mret: got v=%b pc=%h expected v=1 pc=%h", redirect_valid, redirect_pc, tgt); else pass_cnt++;
    do_access(2'd2, 12'h340, 64'd0, 1'b0, 0);
    total_cnt++; if (obs_rd !== 64'h55) $display("FAIL committed_write_kept: got %h expected 55", obs_rd); else pass_cnt++;
    do_access(2'd2, 12'h341, 64'd0, 1'b0, 0);
    total_cnt++; if (obs_rd !== 64'h2000) $display("FAIL trap_over_mret_mepc: got %h expected 2000", obs_rd); else pass_cnt++;
  endtask

  task automatic test_mcycle();
`ifdef CSR_MCYCLE_EN
    logic [63:0] wv [2];
    wv[0] = 64'd100;
    wv[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'd1; req_addr = 12'hB00; req_wdata = wv[k]; req_wen = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'd2; req_wdata = 64'd0;
      @(posedge clk);
      @(posedge clk);
      #1 req_valid = 1'b0; rsp_ready = 1'b0;
      @(negedge clk);
      total_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== wv[k] + 64'd1) $display("FAIL mcycle_count: got v=%b rd=%h expected v=1 rd=%h", rsp_valid, rsp_rdata, wv[k] + 64'd1); else pass_cnt++;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
`else
    do_access(2'd2, 12'hB00, 64'd0, 1'b0, 0);
    total_cnt++; if (obs_ill !== 1'b1 || obs_rd !== 64'd0) $display("FAIL mcycle_absent: got ill=%b rd=%h expected ill=1 rd=0", obs_ill, obs_rd); else pass_cnt++;
`endif
  endtask

  task automatic test_random();
    logic [11:0] addrs [13];
    logic [1:0]  op;
    logic [11:0] a;
    logic [63:0] w, c, p, tgt;
    logic        wen;
    int          r;
    addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h310, 12'h340, 12'h341,
              12'h342, 12'h343, 12'h344, 12'hF14, 12'h7C0,
`ifdef CSR_MCYCLE_EN
              12'h3A0};
`else
              12'hB00};
`endif
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        op  = 2'($urandom_range(0, 3));
        a   = addrs[$urandom_range(0, 12)];
        w   = {$urandom, $urandom};
        wen = 1'($urandom_range(0, 1));
        model_access(op, a, w, wen, exp_rd, exp_ill);
        do_access(op, a, w, wen, 0);
        total_cnt++; if (obs_vld !== 1'b1 || obs_rd !== exp_rd || obs_ill !== exp_ill)
          $display("FAIL rand_access[%0d] op=%0d addr=%h: got v=%b rd=%h ill=%b expected v=1 rd=%h ill=%b", n, op, a, obs_vld, obs_rd, obs_ill, exp_rd, exp_ill);
        else pass_cnt++;
      end else if (r == 7) begin
        c = {$urandom, $urandom};
        p = {$urandom, $urandom};
        tgt = model_target(c);
        do_event(1'b1, 1'b0, c, p, 64'(n));
        model_trap(c, p, 64'(n));
        total_cnt++; if (ev_rv !== 1'b1 || ev_pc !== tgt) $display("FAIL rand_trap[%0d]: got v=%b pc=%h expected v=1 pc=%h", n, ev_rv, ev_pc, tgt); else pass_cnt++;
      end else if (r == 8) begin
        tgt = m_mepc;
        do_event(1'b0, 1'b1, 64'd0, 64'd0, 64'd0);
        model_mret();
        total_cnt++; if (ev_rv !== 1'b1 || ev_pc !== tgt) $display("FAIL rand_mret[%0d]: got v=%b pc=%h expected v=1 pc=%h", n, ev_rv, ev_pc, tgt); else pass_cnt++;
      end else begin
        @(negedge clk);
        msip = 1'($urandom_range(0, 1)); mtip = 1'($urandom_range(0, 1)); meip = 1'($urandom_range(0, 1));
        #1;
        total_cnt++; if (irq_take !== model_irq()) $display("FAIL rand_irq[%0d]: got %b expected %b", n, irq_take, model_irq()); else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_mscratch();
    test_mtvec_warl();
    test_illegal();
    test_exception_trap();
    test_interrupt();
    test_trap_mret_resp();
    test_mcycle();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
